// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes,
// conversion FSM encoding and the nibble-to-segment decoder.
package ssd_pkg;

  // Segment bit order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg_s;
    case (nib)
      4'd0:    seg_s = SEG_0;
      4'd1:    seg_s = SEG_1;
      4'd2:    seg_s = SEG_2;
      4'd3:    seg_s = SEG_3;
      4'd4:    seg_s = SEG_4;
      4'd5:    seg_s = SEG_5;
      4'd6:    seg_s = SEG_6;
      4'd7:    seg_s = SEG_7;
      4'd8:    seg_s = SEG_8;
      4'd9:    seg_s = SEG_9;
      default: seg_s = SEG_BLANK;
    endcase
    return seg_s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, committed result
// and sticky overflow held until the next accepted load.
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 4
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VALUE_W - 1);

  conv_state_e        state_r, state_s;
  logic [VALUE_W-1:0] bin_r;
  logic [BCD_W-1:0]   work_r, adj_s, disp_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sticky_r, ovf_r, busy_r;

  // Next-state selection for the conversion FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (load) state_s = ST_SHIFT; else state_s = ST_IDLE;
      ST_SHIFT:  if (cnt_r == LAST_CNT) state_s = ST_COMMIT; else state_s = ST_SHIFT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Add-3 correction of every nibble that would exceed 9 after doubling
  always_comb begin
    adj_s = work_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = work_r[4*i +: 4] + 4'd3;
      else adj_s[4*i +: 4] = work_r[4*i +: 4];
    end
  end

  // FSM state register
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Shift datapath, overflow tracking and committed result
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      bin_r    <= '0;
      work_r   <= '0;
      disp_r   <= '0;
      cnt_r    <= '0;
      sticky_r <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r    <= value;
            work_r   <= '0;
            cnt_r    <= '0;
            sticky_r <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // A 1 leaving the top nibble means the value needs more digits
          work_r   <= {adj_s[BCD_W-2:0], bin_r[VALUE_W-1]};
          bin_r    <= bin_r << 1;
          sticky_r <= sticky_r | adj_s[BCD_W-1];
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        ST_COMMIT: begin
          disp_r <= work_r;
          ovf_r  <= sticky_r;
          busy_r <= 1'b0;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign busy = busy_r;
  assign bcd  = disp_r;
  assign ovf  = ovf_r;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver with binary-to-BCD front end.
// Optional leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int VALUE_W   = 16,
  parameter int REFRESH_W = 17
) (
  input  logic                ClkPort,
  input  logic                Reset,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [REFRESH_W-1:0] refresh_r;
  logic [IDX_W-1:0]     idx_r;
  logic [4*DIGITS-1:0]  disp_bcd_s;
  logic                 ovf_s;
  logic                 blank_s;
  logic [3:0]           nib_s;
  logic [6:0]           seg_s, seg_r;
  logic [DIGITS-1:0]    anode_s, anode_r;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .value   (value),
    .load    (load),
    .busy    (busy),
    .bcd     (disp_bcd_s),
    .ovf     (ovf_s)
  );

  // Free-running refresh counter; the digit index steps on its wrap
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      refresh_r <= '0;
      idx_r     <= '0;
    end else begin
      refresh_r <= refresh_r + REFRESH_W'(1);
      if (&refresh_r) begin
        if (idx_r == LAST_IDX) idx_r <= '0;
        else                   idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic [DIGITS:0] lz_s;

  // A digit is a leading zero when it and every higher nibble are zero
  always_comb begin
    lz_s         = '0;
    lz_s[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_s[i] = lz_s[i+1] & (disp_bcd_s[4*i +: 4] == 4'd0);
    end
  end

  assign blank_s = (idx_r != '0) && lz_s[idx_r];
`else
  assign blank_s = 1'b0;
`endif

  // Segment and anode pattern for the digit currently being scanned
  always_comb begin
    nib_s = disp_bcd_s[idx_r*4 +: 4];
    if (ovf_s)        seg_s = SEG_DASH;
    else if (blank_s) seg_s = SEG_BLANK;
    else              seg_s = seg_decode(nib_s);
    anode_s = ~(DIGITS'(1) << idx_r);
  end

  // Anode and segment pins update together to avoid ghosting
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      anode_r <= '1;
      seg_r   <= SEG_BLANK;
    end else begin
      anode_r <= anode_s;
      seg_r   <= seg_s;
    end
  end

  assign ovf   = ovf_s;
  assign anode = anode_r;
  assign seg   = seg_r;
  assign dp    = 1'b1;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised multi-digit seven-segment score display for the pong top level. It replaces the fixed 4-digit counter scanner. It accepts a binary score, converts it to BCD with a sequential double-dabble engine, and time-multiplexes up to 8 digits onto shared cathodes with active-low anodes. Out-of-range values are flagged and shown as dashes.

## Interface
- DIGITS, 4: number of digits scanned, 1..8.
- VALUE_W, 16: width of the binary input value, 1..27.
- REFRESH_W, 17: width of the refresh counter. Each digit is held for 2^REFRESH_W clocks.
- ClkPort  in  1  system clock (100 MHz).
- Reset  in  1  asynchronous, active-high reset.
- value  in  VALUE_W  binary number to display.
- load  in  1  single-cycle request to sample `value`.
- busy  out  1  conversion in progress. `load` is ignored while high.
- ovf  out  1  the last committed value was ≥ 10^DIGITS.
- anode  out  DIGITS  digit enables, active-low, one-hot-low.
- seg  out  7  {a,b,c,d,e,f,g} cathodes, active-low.
- dp  out  1  decimal point, constant 1 (off).

## Operation
- Conversion FSM states:
  - IDLE: on `load`=1, capture `value` into the shift register, clear the BCD register (4·DIGITS bits) and the sticky overflow bit, then go to SHIFT. `load` has no effect in any other state.
  - SHIFT: runs exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble ≥ 5. Then shift {bcd, bin} left by 1. If a 1 leaves the top BCD nibble, set the sticky overflow bit. After cycle VALUE_W, go to COMMIT.
  - COMMIT: copy the BCD register to the display register and the sticky bit to `ovf`, then go to IDLE.
- `busy` is 1 in SHIFT and COMMIT, and 0 in IDLE.
- Scan:
  - The refresh counter is free-running. When it reaches all-ones, the digit index increments.
  - The index wraps from DIGITS-1 to 0.
  - The index is independent of the conversion FSM and is never reset by `load`.
- Segment source for the current index:
  - If `ovf`=1: SEG_DASH (only g lit) on every digit.
  - Otherwise: the decoded nibble. Nibbles 10..15 never occur; decode them to SEG_BLANK.
- Reset values: FSM IDLE, `busy` 0, `ovf` 0, display register 0, index 0, refresh counter 0, `anode` all 1s, `seg` 7'h7F, `dp` 1.
- Reset asserted mid-conversion aborts the conversion. The display register keeps no partial result; it is reset to 0.

## Timing
- `load` sampled high at edge t:
  - SHIFT occupies edges t+1 … t+VALUE_W.
  - COMMIT is at edge t+VALUE_W+1, when the display register, `ovf` and `busy`=0 all update.
  - Total latency from `load` to the new display register is VALUE_W+1 edges.
- The earliest accepted back-to-back `load` is at edge t+VALUE_W+2.
- `anode` and `seg` are registered, so the pins follow the index and display register one cycle later.
- Anode and segment change on the same edge, so no ghosting is introduced.
- Only the index digit's anode bit is 0 at any time. After reset, all anode bits are 1 until the first clock.

## Configuration
- SSD_LZ_BLANK_EN defined:
  - Digit i (i ≥ 1) shows SEG_BLANK when nibble i and all higher nibbles are 0.
  - Digit 0 is always shown, so a value of 0 displays a single "0".
  - Blanking does not apply when `ovf`=1.
- SSD_LZ_BLANK_EN undefined: every digit shows its decoded nibble, including leading zeros.

## Structure
- Shared package `ssd_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_BLANK (7'h7F) and SEG_DASH (7'h7E);
  - the FSM state encoding;
  - the nibble-to-segment decode function.
- Sub-module `bin2bcd_seq` (parameters VALUE_W and DIGITS) contains the IDLE/SHIFT/COMMIT FSM. Its outputs are `busy`, the committed BCD and `ovf`.
- The top of the block contains the refresh counter, the index, blanking and the output registers.

## Test plan
All scenarios use DIGITS=4, VALUE_W=16, REFRESH_W=2.
- Reset, no load: `anode`=4'hF and `seg`=7'h7F during Reset. After release, anodes cycle 1110→1101→1011→0111 every 4 clocks, showing "0000" (macro off) or blank/blank/blank/"0" (macro on).
- `load` with `value`=1234: `busy` is high for 17 clocks and the display register becomes 16'h1234. The scan shows 4,3,2,1 on anode 0..3 and `ovf`=0.
- `value`=10000: `ovf`=1 after commit and all digits show 7'h7E. A following `value`=9999 clears `ovf` and shows 9999.
- `load`=1 with `value`=42 while `busy`=1, 5 cycles into converting 1234: the second load is ignored and the result is 1234.
- Reset pulsed at SHIFT cycle 8: `busy`=0, the display register is 0 and `ovf`=0. The next load of 77 commits correctly 17 cycles later.
- SSD_LZ_BLANK_EN defined, `value`=7: digits 3..1 are SEG_BLANK and digit 0 is SEG_7. With `value`=0, only digit 0 shows SEG_0.
